// File: rtl/fp_align_pipe.sv
// Floating-point operand alignment: picks the larger operand and right-shifts the smaller mantissa with G/R/S.
// Latency: 2 cycles from input transfer to out_valid; 1 pair/cycle throughput when out_ready stays high.
// Backpressure: valid/ready elastic pipeline; in_ready = !v1 || (!v2 || out_ready), outputs hold while stalled.
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic [EXP_W-1:0]   exp_a,
  input  logic [EXP_W-1:0]   exp_b,
  input  logic [MAN_W-1:0]   mant_a,
  input  logic [MAN_W-1:0]   mant_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   exp_large,
  output logic               sign_large,
  output logic               sign_small,
  output logic [MAN_W+2:0]   mant_large,
  output logic [MAN_W+2:0]   mant_small,
  output logic               swapped,
  output logic               shift_sat
);

  // Aligned width: mantissa followed by guard, round and sticky bits.
  localparam int AW = MAN_W + 3;

  typedef struct packed {
    logic [MAN_W-1:0] mant_l;
    logic [MAN_W-1:0] mant_s;
    logic             sign_l;
    logic             sign_s;
    logic [EXP_W-1:0] exp_l;
    logic [EXP_W-1:0] diff;
    logic             swap;
  } s1_t;

  typedef struct packed {
    logic [EXP_W-1:0] exp_l;
    logic             sign_l;
    logic             sign_s;
    logic [AW-1:0]    mant_l;
    logic [AW-1:0]    mant_s;
    logic             swap;
    logic             sat;
  } s2_t;

  logic v1_q, v2_q;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic adv2;
  logic load1, load2;

  // Stage 2 moves whenever it is empty or its result is being taken; stage 1 refills behind it.
  assign adv2      = !v2_q || out_ready;
  assign in_ready  = !v1_q || adv2;
  assign load1     = in_valid && in_ready;
  assign load2     = adv2 && v1_q;
  assign out_valid = v2_q;

  // Stage 1: magnitude compare; an exact tie keeps A as the large operand.
  always_comb begin
    logic b_large;
    s1_d    = '0;
    b_large = (exp_b > exp_a) || ((exp_b == exp_a) && (mant_b > mant_a));
    if (b_large) begin
      s1_d.mant_l = mant_b;
      s1_d.mant_s = mant_a;
      s1_d.sign_l = sign_b;
      s1_d.sign_s = sign_a;
      s1_d.exp_l  = exp_b;
      s1_d.diff   = exp_b - exp_a;
      s1_d.swap   = 1'b1;
    end else begin
      s1_d.mant_l = mant_a;
      s1_d.mant_s = mant_b;
      s1_d.sign_l = sign_a;
      s1_d.sign_s = sign_b;
      s1_d.exp_l  = exp_a;
      s1_d.diff   = exp_a - exp_b;
      s1_d.swap   = 1'b0;
    end
  end

  // Stage 2: right shift with sticky collapse; shifts of AW or more leave only the sticky bit.
  always_comb begin
    logic [AW-1:0] x;
    logic [AW-1:0] shifted;
    logic [AW-1:0] mask;
    logic          sticky;
    logic          sat;
    x        = {s1_q.mant_s, 3'b000};
    shifted  = x >> s1_q.diff;
    mask     = ~({AW{1'b1}} << s1_q.diff);
    sticky   = |(x & mask);
    sat      = (32'(s1_q.diff) >= AW);
    s2_d        = '0;
    s2_d.exp_l  = s1_q.exp_l;
    s2_d.sign_l = s1_q.sign_l;
    s2_d.sign_s = s1_q.sign_s;
    s2_d.mant_l = {s1_q.mant_l, 3'b000};
    s2_d.swap   = s1_q.swap;
    s2_d.sat    = sat;
    if (sat) begin
      s2_d.mant_s = {{(AW-1){1'b0}}, |s1_q.mant_s};
    end else begin
      s2_d.mant_s = shifted | {{(AW-1){1'b0}}, sticky};
    end
  end

  // Stage valid bits: stage 1 takes in_valid whenever it can accept, stage 2 takes v1 on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (in_ready) v1_q <= in_valid;
      if (adv2)     v2_q <= v1_q;
    end
  end

  // Stage data registers load only on an actual transfer so stalled results stay put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (load1) s1_q <= s1_d;
      if (load2) s2_q <= s2_d;
    end
  end

  assign exp_large  = s2_q.exp_l;
  assign sign_large = s2_q.sign_l;
  assign sign_small = s2_q.sign_s;
  assign mant_large = s2_q.mant_l;
  assign mant_small = s2_q.mant_s;
  assign swapped    = s2_q.swap;
  assign shift_sat  = s2_q.sat;

endmodule
